// File: rtl/retire_stage_pkg.sv
// Shared types for the retire stage: ROB exit payload and retire FSM states.
`ifndef N
`define N 4
`endif
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif

package retire_stage_pkg;

    localparam int unsigned RETIRE_N      = `N;
    localparam int unsigned ROB_TAG_BITS  = $clog2(`PHYS_REG_SZ);
    localparam int unsigned ARCH_REG_BITS = 5;

    // One ROB head entry as seen by the retire stage.
    typedef struct packed {
        logic                     complete;
        logic                     mispred;
        logic                     halt;
        logic [ARCH_REG_BITS-1:0] arch_reg;
        logic [ROB_TAG_BITS-1:0]  t_new;
        logic [ROB_TAG_BITS-1:0]  t_old;
    } ROB_EXIT_PACKET;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_HALTED = 2'd2
    } retire_state_e;

endpackage

// File: rtl/retire_stage.sv
// In-order retire stage at the ROB head: picks the retiring prefix, frees old
// tags, updates the architectural map, and sequences flush / halt.
`ifndef N
`define N 4
`endif
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif

module retire_stage
    import retire_stage_pkg::*;
#(
    parameter int unsigned N               = `N,
    parameter int unsigned NUM_SCALAR_BITS = $clog2(N + 1),
    parameter int unsigned PHYS_REG_BITS   = $clog2(`PHYS_REG_SZ)
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  ROB_EXIT_PACKET [N-1:0]                rob_outputs,
    input  logic [NUM_SCALAR_BITS-1:0]            outputs_valid,
    output logic [NUM_SCALAR_BITS-1:0]            num_retiring,
    output logic [N-1:0]                          free_valid,
    output logic [N-1:0][PHYS_REG_BITS-1:0]       free_tag,
    output logic [N-1:0]                          amt_we,
    output logic [N-1:0][ARCH_REG_BITS-1:0]       amt_idx,
    output logic [N-1:0][PHYS_REG_BITS-1:0]       amt_tag,
    output logic                                  flush,
    output logic                                  halted,
    output logic [31:0]                           retired_count
);

    retire_state_e               state_q, state_d;
    logic                        flush_q, flush_d;
    logic                        halted_q, halted_d;
    logic [31:0]                 retired_count_q, retired_count_d;

    logic [N-1:0]                retire_c;
    logic [NUM_SCALAR_BITS-1:0]  num_retiring_c;
    logic                        mispred_c;
    logic                        halt_c;
    logic                        blocked_c;

    // Retire prefix selection, per-lane map/free outputs and next-state logic.
    always_comb begin
        state_d         = state_q;
        retire_c        = '0;
        num_retiring_c  = '0;
        mispred_c       = 1'b0;
        halt_c          = 1'b0;
        blocked_c       = reset || (state_q != ST_RUN);
        free_valid      = '0;
        free_tag        = '0;
        amt_we          = '0;
        amt_idx         = '0;
        amt_tag         = '0;

        // Walk lanes oldest first; the first non-retiring lane or a retiring
        // redirect (mispred/halt) stops every younger lane.
        for (int i = 0; i < N; i++) begin
            if (!blocked_c && (32'(i) < 32'(outputs_valid)) && rob_outputs[i].complete) begin
                retire_c[i]    = 1'b1;
                num_retiring_c = num_retiring_c + NUM_SCALAR_BITS'(1);
                if (rob_outputs[i].halt) begin
                    halt_c = 1'b1;
                end else if (rob_outputs[i].mispred) begin
                    mispred_c = 1'b1;
                end
                blocked_c = rob_outputs[i].halt || rob_outputs[i].mispred;
            end else begin
                blocked_c = 1'b1;
            end
        end

        // x0 has no mapping, so it neither writes the map nor frees a tag.
        for (int i = 0; i < N; i++) begin
            free_valid[i] = retire_c[i] && (rob_outputs[i].arch_reg != '0);
            amt_we[i]     = retire_c[i] && (rob_outputs[i].arch_reg != '0);
            if (!reset) begin
                free_tag[i] = PHYS_REG_BITS'(rob_outputs[i].t_old);
                amt_idx[i]  = rob_outputs[i].arch_reg;
                amt_tag[i]  = PHYS_REG_BITS'(rob_outputs[i].t_new);
            end
        end

        case (state_q)
            ST_RUN: begin
                if (halt_c) begin
                    state_d = ST_HALTED;
                end else if (mispred_c) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH:  state_d = ST_RUN;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase

        flush_d         = (state_d == ST_FLUSH);
        halted_d        = (state_d == ST_HALTED);
        retired_count_d = retired_count_q + 32'(num_retiring_c);
    end

    // State, status flags and retire counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= ST_RUN;
            flush_q         <= 1'b0;
            halted_q        <= 1'b0;
            retired_count_q <= '0;
        end else begin
            state_q         <= state_d;
            flush_q         <= flush_d;
            halted_q        <= halted_d;
            retired_count_q <= retired_count_d;
        end
    end

    assign num_retiring  = num_retiring_c;
    assign flush         = flush_q;
    assign halted        = halted_q;
    assign retired_count = retired_count_q;

endmodule

// File: doc/retire_stage.md
# retire_stage

In-order retire stage that sits at the ROB head, the consumer end of the ROB exit interface. Each cycle it examines up to `N` head entries (`rob_outputs`/`outputs_valid`). It returns `num_retiring` to the ROB in the same cycle, releases old physical registers to the free list and updates the architectural map. It also raises a one-cycle registered flush on a retiring mispredicted branch and latches a halt state on a retiring halt instruction.

## Interface
- `N`, default `` `N ``: maximum retire width.
- `NUM_SCALAR_BITS`, default `$clog2(N+1)`: width of count ports.
- `PHYS_REG_BITS`, default `$clog2(`PHYS_REG_SZ)`: physical register tag width.
- `clock`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `rob_outputs`, input, `ROB_EXIT_PACKET [N-1:0]`: ROB head entries, index 0 oldest. Fields used: `.complete`, `.mispred`, `.halt`, `.arch_reg`, `.t_new`, `.t_old`.
- `outputs_valid`, input, `NUM_SCALAR_BITS`: number of valid head entries.
- `num_retiring`, output, `NUM_SCALAR_BITS`: entries the ROB clears at this edge (combinational).
- `free_valid`, output, `N`: bit i means `free_tag[i]` is released this cycle.
- `free_tag`, output, `[N-1:0][PHYS_REG_BITS-1:0]`: `rob_outputs[i].t_old`.
- `amt_we`, output, `N`: bit i means write `amt_tag[i]` to arch reg `amt_idx[i]`.
- `amt_idx` / `amt_tag`, output, per-lane arch index / `t_new`.
- `flush`, output, 1: registered one-cycle pulse; the pipeline squashes all younger state.
- `halted`, output, 1: registered; the processor has retired a halt.
- `retired_count`, output, 32: total instructions retired since reset.

## Operation
- States:
  - RUN: normal retire.
  - FLUSH: one cycle, no retire.
  - HALTED: terminal, no retire.
- Lane i retires iff all of the following hold:
  - the state is RUN;
  - i < `outputs_valid`;
  - `rob_outputs[i].complete` is set;
  - every lane j<i retires;
  - no lane j<i has `.mispred` or `.halt` set.
- Retirement is strictly in order. A non-complete entry blocks itself and all younger lanes.
- The mispredicting or halting entry itself retires: it updates the map, frees `t_old`, and is counted. Younger lanes in the same group do not retire.
- `num_retiring` equals the count of retiring lanes, which always forms a contiguous prefix.
  - `num_retiring` ≤ `outputs_valid` at all times.
  - `num_retiring` is 0 outside RUN.
- `free_valid[i]`, `amt_we[i]` equal the retire bit of lane i. Lanes with `arch_reg == 0` get `amt_we=0` and `free_valid=0` (x0 has no mapping).
- Transitions:
  - RUN to FLUSH: a retiring lane has `.mispred`.
  - RUN to HALTED: a retiring lane has `.halt`. If both occur, the older lane wins; a halt and a mispred cannot retire in the same group.
  - FLUSH to RUN: unconditionally after one cycle.
  - HALTED stays HALTED until reset.
- `flush` is high exactly during the FLUSH state. `halted` is high exactly in HALTED.
- `retired_count` is incremented by `num_retiring` at each edge and wraps modulo 2^32.

## Timing
- Reset (async assert, takes effect immediately): state RUN, `flush`=0, `halted`=0, `retired_count`=0. All combinational outputs are 0 while reset is high.
- `num_retiring`, `free_*`, `amt_*`: combinational from `rob_outputs`/`outputs_valid`/state in the same cycle. The ROB, free list and map table consume them at the next rising edge.
- `flush` is asserted the cycle after the mispredicted branch retires. It lasts exactly one cycle. The ROB is expected to be empty (`outputs_valid`=0) that cycle; any valid entries present are ignored.
- `halted` is asserted the cycle after the halt retires and holds.
- Boundaries:
  - `outputs_valid`=0 gives `num_retiring`=0.
  - All N lanes complete with no mispred or halt gives `num_retiring`=N.
  - A lane with `complete` set above a non-complete lane does not retire.
  - Reset asserted during FLUSH or HALTED returns to RUN with `flush`=0 in the same cycle.
  - A new mispred can retire in the first RUN cycle after FLUSH.

## Test plan
- Reset:
  - Stimulus: assert reset mid-run.
  - Required: `flush`=0, `halted`=0, `retired_count`=0, `num_retiring`=0 immediately. After release, 4 complete entries (N=4) retire with `num_retiring`=4.
- Partial completion:
  - Stimulus: `outputs_valid`=3, lanes complete = {1,0,1}.
  - Required: `num_retiring`=1, `free_valid`=0001, `retired_count` +1 next edge.
- Mispredict:
  - Stimulus: 3 complete entries, lane 1 `.mispred`.
  - Required: `num_retiring`=2. Next cycle `flush`=1 and `num_retiring`=0 with a valid complete input. The following cycle `flush`=0 and retire resumes.
- Halt:
  - Stimulus: lane 0 `.halt`, lanes 1-2 complete.
  - Required: `num_retiring`=1. Then `halted`=1 and `num_retiring`=0 for 10 cycles despite complete inputs.
- x0 destination:
  - Stimulus: 2 complete entries, lane 0 `arch_reg`=0, lane 1 `arch_reg`=5 with `t_new`=40, `t_old`=12.
  - Required: `amt_we`=10, `free_valid`=10, `free_tag[1]`=12, `num_retiring`=2.
- Counter wrap:
  - Stimulus: force `retired_count` to 0xFFFFFFFE and retire 3.
  - Required: `retired_count`=1.
